// File: rtl/icache_assoc.sv
// icache_assoc: set-associative instruction cache (1 or 2 ways, multi-word
// blocks) with per-set LRU replacement, a blocking miss/fill FSM and a
// synchronous flush. Sits between instruction fetch and the memory port.
//
// Memory handshake: a read is offered while iREN=1 on iaddr; the word on
// iload is taken on the rising edge where iREN=1 and iwait=0. iREN stays
// high across consecutive words of one block, with no idle cycle between.
module icache_assoc #(
  parameter int SETS        = 8,
  parameter int WAYS        = 2,
  parameter int BLOCK_WORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        flush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic        dbg_state
);

  localparam int WO_W    = $clog2(BLOCK_WORDS);
  localparam int WO_S    = (WO_W > 0) ? WO_W : 1;
  localparam int IDX_W   = $clog2(SETS);
  localparam int IDX_LSB = 2 + WO_W;
  localparam int TAG_W   = 30 - WO_W - IDX_W;
  localparam int WAY_W   = 1;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [WO_S-1:0]    cnt_q, cnt_d;
  logic [31:0]        base_q, base_d;
  logic [WAY_W-1:0]   victim_q, victim_d;
  logic [SETS-1:0]    lru_q, lru_d;
  logic [WAYS-1:0]    valid_q [SETS];
  logic [WAYS-1:0]    valid_d [SETS];
  logic [TAG_W-1:0]   tag_q [SETS][WAYS];
  logic [TAG_W-1:0]   tag_d [SETS][WAYS];
  logic [31:0]        data_q [SETS][WAYS][BLOCK_WORDS];

  logic [WO_S-1:0]    req_wo;
  logic [IDX_W-1:0]   req_idx, fill_idx;
  logic [TAG_W-1:0]   req_tag, fill_tag;
  logic               hit_any;
  logic [WAY_W-1:0]   hit_way;
  logic [31:0]        hit_word;
  logic [WAY_W-1:0]   victim_pick;
  logic               fill_we;

  assign req_wo   = (WO_W == 0) ? '0 : imemaddr[2 +: WO_S];
  assign req_idx  = imemaddr[IDX_LSB +: IDX_W];
  assign req_tag  = imemaddr[31 -: TAG_W];
  assign fill_idx = base_q[IDX_LSB +: IDX_W];
  assign fill_tag = base_q[31 -: TAG_W];
  assign dbg_state = state_q;

  // Tag compare across the ways of the requested set; at most one matches.
  always_comb begin
    hit_any  = 1'b0;
    hit_way  = '0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
        for (int b = 0; b < BLOCK_WORDS; b++) begin
          if (WO_S'(b) == req_wo) hit_word = data_q[req_idx][w][b];
        end
      end
    end
  end

  assign ihit     = imemREN & (state_q == IDLE) & ~flush & hit_any;
  assign imemload = ihit ? hit_word : '0;

  // Victim: lowest-numbered invalid way, otherwise the set's LRU way.
  always_comb begin
    logic found;
    found       = 1'b0;
    victim_pick = (WAYS == 1) ? '0 : lru_q[req_idx];
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_q[req_idx][w]) begin
        victim_pick = WAY_W'(w);
        found       = 1'b1;
      end
    end
  end

  // Miss/fill FSM next state, memory request and metadata updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    victim_d = victim_q;
    lru_d    = lru_q;
    valid_d  = valid_q;
    tag_d    = tag_q;
    iREN     = 1'b0;
    iaddr    = '0;
    fill_we  = 1'b0;
    if (flush) begin
      // Flush wins over hit, miss and fill completion.
      for (int s = 0; s < SETS; s++) valid_d[s] = '0;
      lru_d   = '0;
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ihit) begin
            if (WAYS == 2) lru_d[req_idx] = ~hit_way[0];
          end else if (imemREN) begin
            state_d  = FILL;
            base_d   = {imemaddr[31:IDX_LSB], {IDX_LSB{1'b0}}};
            victim_d = victim_pick;
            cnt_d    = '0;
          end
        end
        FILL: begin
          iREN  = 1'b1;
          iaddr = base_q + 32'({cnt_q, 2'b00});
          if (!imemREN) begin
            // Fetch withdrawn: drop the partial block, line stays invalid.
            state_d = IDLE;
            cnt_d   = '0;
          end else if (!iwait) begin
            fill_we = 1'b1;
            cnt_d   = cnt_q + WO_S'(1);
            if (cnt_q == WO_S'(BLOCK_WORDS - 1)) begin
              for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == victim_q) begin
                  valid_d[fill_idx][w] = 1'b1;
                  tag_d[fill_idx][w]   = fill_tag;
                end
              end
              if (WAYS == 2) lru_d[fill_idx] = ~victim_q[0];
              state_d = IDLE;
              cnt_d   = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control and metadata registers, cleared asynchronously.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      base_q   <= '0;
      victim_q <= '0;
      lru_q    <= '0;
      valid_q  <= '{default: '0};
      tag_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      victim_q <= victim_d;
      lru_q    <= lru_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
    end
  end

  // Data array: written one word per accepted memory beat, never reset.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int b = 0; b < BLOCK_WORDS; b++) begin
          if ((WAY_W'(w) == victim_q) && (WO_S'(b) == cnt_q)) begin
            data_q[fill_idx][w][b] <= iload;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: directed tests for icache_assoc in the default 2-way,
// 2-word build, plus a 1-way, 4-word build for the direct-mapped case.
module tb_icache_assoc;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  // default build (SETS=8, WAYS=2, BLOCK_WORDS=2)
  logic        imem_ren, flush, iwait, ihit, iren, dbg_state;
  logic [31:0] imem_addr, iload, imemload, iaddr;

  // WAYS=1, BLOCK_WORDS=4 build
  logic        imem_ren1, flush1, iwait1, ihit1, iren1, dbg_state1;
  logic [31:0] imem_addr1, iload1, imemload1, iaddr1;

  icache_assoc #(.SETS(8), .WAYS(2), .BLOCK_WORDS(2)) dut (
    .CLK(clk), .nRST(nrst), .imemREN(imem_ren), .imemaddr(imem_addr),
    .flush(flush), .ihit(ihit), .imemload(imemload), .iREN(iren),
    .iaddr(iaddr), .iwait(iwait), .iload(iload), .dbg_state(dbg_state)
  );

  icache_assoc #(.SETS(8), .WAYS(1), .BLOCK_WORDS(4)) dut1 (
    .CLK(clk), .nRST(nrst), .imemREN(imem_ren1), .imemaddr(imem_addr1),
    .flush(flush1), .ihit(ihit1), .imemload(imemload1), .iREN(iren1),
    .iaddr(iaddr1), .iwait(iwait1), .iload(iload1), .dbg_state(dbg_state1)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] addr_q[$];  // expected memory read addresses, in order
  logic [31:0] exp_q[$];   // expected instruction words on hits
  int n_pass  = 0;
  int n_total = 0;

  // Memory contents model.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h40) return 32'hAAAA_0001;
    if (a == 32'h44) return 32'hAAAA_0002;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Drive phase is 1 time unit after a rising edge; checks run 2 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    imem_ren = 1'b0; imem_addr = '0; flush = 1'b0; iwait = 1'b1; iload = '0;
    imem_ren1 = 1'b0; imem_addr1 = '0; flush1 = 1'b0; iwait1 = 1'b1; iload1 = '0;
    addr_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  // Serve a block fill on the default build with 'waits' busy cycles per word.
  task automatic serve_fill(input logic [31:0] base, input int nwords, input int waits);
    logic [31:0] ea;
    for (int k = 0; k < nwords; k++) addr_q.push_back(base + 32'(4 * k));
    for (int k = 0; k < nwords; k++) begin
      for (int w = 0; w < waits; w++) begin
        iwait = 1'b1;
        #2;
        n_total++;
        if (iren !== 1'b1 || iaddr !== addr_q[0] || ihit !== 1'b0)
          $display("FAIL fill_wait iren=%b iaddr=%h ihit=%b exp iren=1 iaddr=%h ihit=0", iren, iaddr, ihit, addr_q[0]);
        else n_pass++;
        tick();
      end
      ea = addr_q.pop_front();
      iwait = 1'b0;
      iload = mem_data(ea);
      #2;
      n_total++;
      if (iren !== 1'b1 || iaddr !== ea || ihit !== 1'b0)
        $display("FAIL fill_beat iren=%b iaddr=%h ihit=%b exp iren=1 iaddr=%h ihit=0", iren, iaddr, ihit, ea);
      else n_pass++;
      tick();
    end
    iwait = 1'b1;
    iload = '0;
  endtask

  task automatic fetch_hit(input logic [31:0] a);
    logic [31:0] ed;
    imem_ren = 1'b1;
    imem_addr = a;
    exp_q.push_back(mem_data(a));
    #2;
    ed = exp_q.pop_front();
    n_total++;
    if (ihit !== 1'b1 || imemload !== ed || iren !== 1'b0)
      $display("FAIL hit addr=%h ihit=%b data=%h iren=%b exp ihit=1 data=%h iren=0", a, ihit, imemload, iren, ed);
    else n_pass++;
    tick();
  endtask

  task automatic fetch_miss(input logic [31:0] a, input int waits);
    imem_ren = 1'b1;
    imem_addr = a;
    #2;
    n_total++;
    if (ihit !== 1'b0 || imemload !== 32'h0 || iren !== 1'b0)
      $display("FAIL miss addr=%h ihit=%b data=%h iren=%b exp ihit=0 data=0 iren=0", a, ihit, imemload, iren);
    else n_pass++;
    tick();
    serve_fill({a[31:3], 3'b000}, 2, waits);
    fetch_hit(a);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nrst = 1'b0;
    #2;
    n_total++;
    if (ihit !== 1'b0 || imemload !== 32'h0 || iren !== 1'b0 || iaddr !== 32'h0 || dbg_state !== 1'b0)
      $display("FAIL reset ihit=%b data=%h iren=%b iaddr=%h st=%b exp all 0", ihit, imemload, iren, iaddr, dbg_state);
    else n_pass++;
    do_reset();
    n_total++;
    if (ihit1 !== 1'b0 || iren1 !== 1'b0 || iaddr1 !== 32'h0 || dbg_state1 !== 1'b0)
      $display("FAIL reset_w1 ihit=%b iren=%b iaddr=%h st=%b exp all 0", ihit1, iren1, iaddr1, dbg_state1);
    else n_pass++;
  endtask

  task automatic test_basic_fill();
    fetch_miss(32'h40, 2);
    fetch_hit(32'h44);
    imem_ren = 1'b0;
    tick();
  endtask

  task automatic test_lru();
    do_reset();
    fetch_miss(32'h040, 0);   // way0
    fetch_miss(32'h440, 1);   // way1
    fetch_hit(32'h040);       // LRU -> way1
    fetch_miss(32'h840, 0);   // evicts 0x440
    fetch_hit(32'h040);
    fetch_hit(32'h844);
    fetch_miss(32'h440, 0);
    imem_ren = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    do_reset();
    imem_ren = 1'b1;
    imem_addr = 32'h80;
    tick();
    iwait = 1'b0;
    iload = mem_data(32'h80);
    #2;
    n_total++;
    if (iren !== 1'b1 || iaddr !== 32'h80)
      $display("FAIL abort_first iren=%b iaddr=%h exp iren=1 iaddr=00000080", iren, iaddr);
    else n_pass++;
    tick();
    imem_ren = 1'b0;
    iwait = 1'b1;
    tick();
    #2;
    n_total++;
    if (iren !== 1'b0 || dbg_state !== 1'b0 || ihit !== 1'b0)
      $display("FAIL abort_idle iren=%b st=%b ihit=%b exp 0 0 0", iren, dbg_state, ihit);
    else n_pass++;
    tick();
    fetch_miss(32'h80, 0);
    imem_ren = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    fetch_miss(32'h040, 0);
    fetch_miss(32'h440, 0);
    imem_ren = 1'b1;
    imem_addr = 32'h040;
    flush = 1'b1;
    #2;
    n_total++;
    if (ihit !== 1'b0 || iren !== 1'b0 || imemload !== 32'h0)
      $display("FAIL flush_cycle ihit=%b iren=%b data=%h exp 0 0 0", ihit, iren, imemload);
    else n_pass++;
    tick();
    flush = 1'b0;
    fetch_miss(32'h040, 0);
    fetch_miss(32'h440, 0);
    // flush in the middle of a fill
    imem_addr = 32'h0C0;
    tick();
    iwait = 1'b0;
    iload = mem_data(32'h0C0);
    tick();
    flush = 1'b1;
    iwait = 1'b1;
    #2;
    n_total++;
    if (iren !== 1'b0 || ihit !== 1'b0)
      $display("FAIL flush_fill_comb iren=%b ihit=%b exp 0 0", iren, ihit);
    else n_pass++;
    tick();
    flush = 1'b0;
    imem_ren = 1'b0;
    #2;
    n_total++;
    if (iren !== 1'b0 || dbg_state !== 1'b0)
      $display("FAIL flush_fill_after iren=%b st=%b exp 0 0", iren, dbg_state);
    else n_pass++;
    tick();
    fetch_miss(32'h0C0, 0);
    imem_ren = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    fetch_miss(32'h040, 0);
    imem_addr = 32'h0C0;
    tick();
    #2;
    n_total++;
    if (iren !== 1'b1)
      $display("FAIL rst_pre iren=%b exp 1", iren);
    else n_pass++;
    nrst = 1'b0;
    #1;
    n_total++;
    if (iren !== 1'b0 || ihit !== 1'b0 || dbg_state !== 1'b0 || iaddr !== 32'h0)
      $display("FAIL rst_async iren=%b ihit=%b st=%b iaddr=%h exp all 0", iren, ihit, dbg_state, iaddr);
    else n_pass++;
    tick();
    nrst = 1'b1;
    fetch_miss(32'h040, 1);
    imem_ren = 1'b0;
    tick();
  endtask

  task automatic test_ways1_block4();
    logic [31:0] a, ea;
    int pass_round;
    for (int r = 0; r < 3; r++) begin
      a = (r == 1) ? 32'h500 : 32'h100;  // 0x500 shares set 0 with 0x100
      imem_ren1 = 1'b1;
      imem_addr1 = a;
      iwait1 = 1'b0;
      #2;
      n_total++;
      if (ihit1 !== 1'b0 || iren1 !== 1'b0)
        $display("FAIL w1_miss addr=%h ihit=%b iren=%b exp 0 0", a, ihit1, iren1);
      else n_pass++;
      tick();
      for (int k = 0; k < 4; k++) addr_q.push_back(a + 32'(4 * k));
      for (int k = 0; k < 4; k++) begin
        ea = addr_q.pop_front();
        iload1 = mem_data(ea);
        #2;
        n_total++;
        if (iren1 !== 1'b1 || iaddr1 !== ea || ihit1 !== 1'b0)
          $display("FAIL w1_beat iren=%b iaddr=%h ihit=%b exp iren=1 iaddr=%h ihit=0", iren1, iaddr1, ihit1, ea);
        else n_pass++;
        tick();
      end
      pass_round = 0;
      for (int k = 3; k >= 0; k--) begin
        imem_addr1 = a + 32'(4 * k);
        exp_q.push_back(mem_data(imem_addr1));
        #2;
        ea = exp_q.pop_front();
        n_total++;
        if (ihit1 !== 1'b1 || imemload1 !== ea || iren1 !== 1'b0)
          $display("FAIL w1_hit addr=%h ihit=%b data=%h exp ihit=1 data=%h", imem_addr1, ihit1, imemload1, ea);
        else n_pass++;
        tick();
        pass_round++;
      end
    end
    imem_ren1 = 1'b0;
    iwait1 = 1'b1;
    tick();
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    test_reset();
    test_basic_fill();
    test_lru();
    test_abort();
    test_flush();
    test_async_reset();
    test_ways1_block4();
    n_total++;
    if (addr_q.size() != 0 || exp_q.size() != 0)
      $display("FAIL scoreboard_drain addr_q=%0d exp_q=%0d exp 0 0", addr_q.size(), exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
- Parametrised successor to the team's direct-mapped instruction cache.
- Adds N-way associativity (WAYS = 1 or 2), multi-word blocks, an explicit miss/fill state machine driving the memory-side read handshake, per-set LRU replacement, and a synchronous flush.
- Sits between datapath instruction fetch and the memory controller's instruction port.

Parameters:
- SETS, 8, number of sets; power of 2, ≥2.
- WAYS, 2, associativity; 1 or 2 only.
- BLOCK_WORDS, 2, 32-bit words per block; power of 2, ≥1.

Ports:
- CLK  in  1  clock, rising-edge.
- nRST  in  1  asynchronous active-low reset.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address, word aligned.
- flush  in  1  invalidate all lines.
- ihit  out  1  requested word valid on imemload this cycle.
- imemload  out  32  instruction word.
- iREN  out  1  memory read request.
- iaddr  out  32  memory word address.
- iwait  in  1  memory busy; iload valid when iREN=1 and iwait=0.
- iload  in  32  memory read data.

Behaviour:
- Address split:
  - [1:0] byte offset, ignored.
  - Next log2(BLOCK_WORDS) bits: word offset.
  - Next log2(SETS) bits: index.
  - Remainder: tag.
  - Zero-width fields are omitted when BLOCK_WORDS=1.
- Storage per set and way: valid, tag, BLOCK_WORDS data words. Per set: one LRU bit (unused when WAYS=1; LRU names the least recently used way).
- Reset (async, nRST=0):
  - All valid and LRU bits cleared; state=IDLE; fill counter=0.
  - ihit=0, iREN=0, iaddr=0.
  - imemload=0 while ihit=0.
- Hit:
  - Combinational, same cycle: ihit = imemREN & state==IDLE & !flush & some way valid with matching tag.
  - imemload = the matching way's word at the word offset; 0 when no hit.
  - At most one way can match.
  - On the hit edge, LRU[index] <= the other way.
- FSM states: IDLE, FILL.
- IDLE → FILL:
  - Condition: imemREN & !ihit & !flush.
  - Latch block base address (imemaddr with word offset and byte offset zeroed).
  - Latch victim way: lowest-numbered invalid way in the set, else the LRU way.
  - Fill counter <= 0.
- FILL:
  - iREN=1; iaddr = base + 4*counter.
  - On each edge with iwait=0: store iload into the victim way at word [counter]; counter++.
  - On the edge accepting word BLOCK_WORDS-1:
    - Write tag and set valid.
    - LRU[index] <= the other way (relative to the victim).
    - Return to IDLE.
  - The fetch hits on the following cycle.
  - ihit=0 throughout FILL.
- Fill uses only the latched base. Changes to imemaddr during FILL do not redirect it; the new address is looked up after the return to IDLE.
- imemREN falling during FILL: abort at the next edge, return to IDLE. Line stays invalid; words already written are discarded; LRU unchanged.
- flush=1:
  - Next edge: all valid and LRU bits clear; any fill aborts; state=IDLE.
  - ihit=0 and iREN=0 combinationally during the flush cycle.
  - Flush has priority over hit, miss and fill completion.
- Memory is read one word per handshake. iREN stays asserted across consecutive words with no idle cycle between them.
- WAYS=1: victim is always way 0. Behaves as direct-mapped with multi-word blocks.
- Index wrap: addresses differing only in tag map to the same set and compete for its ways.

Test Plan (SETS=8, WAYS=2, BLOCK_WORDS=2; word offset=[2], index=[5:3], tag=[31:6]):
1. Reset, then imemREN=1, imemaddr=0x0000_0040:
   - Miss; iREN=1, iaddr=0x40 then 0x44.
   - iwait=1 for 2 cycles, then 0; iload=0xAAAA_0001, 0xAAAA_0002.
   - Cycle after the second word: ihit=1, imemload=0xAAAA_0001.
   - Address 0x44 then hits with 0xAAAA_0002, iREN=0.
2. Fill 0x040 (way0), then 0x440 (same set 0, tag 0x11, way1); access 0x040 (hit, LRU→way1); miss on 0x840:
   - Replaces way1.
   - 0x040 still hits; 0x440 misses.
3. Deassert imemREN after the first word of a 0x080 fill:
   - FSM returns to IDLE, iREN=0.
   - A later 0x080 access misses and refetches from iaddr=0x80.
4. Two lines resident, flush=1 for one cycle:
   - ihit=0 during the flush cycle.
   - Both addresses subsequently miss.
   - Flush asserted mid-fill aborts the fill; iREN=0 on the next cycle.
5. nRST low mid-fill:
   - iREN and ihit drop immediately (asynchronous).
   - After release, a previously resident line misses.
6. WAYS=1, BLOCK_WORDS=4 build:
   - Miss on 0x100 issues 4 reads (iaddr=0x100, 0x104, 0x108, 0x10C) with iwait=0 throughout.
   - The next access to 0x10C hits.
